// File: rtl/xcore_gnrl_skid_buf_if.sv
// xcore_gnrl_skid_buf_if: valid/ready/payload handshake bundle for one side of a pipeline stage
interface xcore_gnrl_skid_buf_if #(parameter int DW = 8);
    logic          vld;
    logic          rdy;
    logic [DW-1:0] dat;
    modport master (output vld, output dat, input rdy);
    modport slave  (input vld, input dat, output rdy);
endinterface

// File: rtl/xcore_gnrl_skid_buf.sv
// xcore_gnrl_skid_buf: 2-entry skid buffer with registered valid/ready and sync flush
module xcore_gnrl_skid_buf #(
    parameter int DW = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    input logic                   flush,
    xcore_gnrl_skid_buf_if.slave  i_if,
    xcore_gnrl_skid_buf_if.master o_if
);
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
    state_t        state;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          push;
    logic          pop;
    // Handshake outputs come straight from state so no input reaches an output combinationally.
    assign i_if.rdy = (state != FULL);
    assign o_if.vld = (state != EMPTY);
    assign o_if.dat = main_q;
    assign push     = i_if.vld & i_if.rdy;
    assign pop      = o_if.vld & o_if.rdy;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (push) begin
                    state  <= BUSY;
                    main_q <= i_if.dat;
                end
                BUSY: begin
                    state  <= (push && !pop) ? FULL : (pop && !push) ? EMPTY : BUSY;
                    if (push && pop) main_q <= i_if.dat;
                    if (push && !pop) skid_q <= i_if.dat;
                end
                FULL: if (pop) begin
                    state  <= BUSY;
                    main_q <= skid_q;
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule
